score_reader: RTL and testbench
===============================

Name: score_reader

Overview:
- Read-side counterpart of the game controller that records reaction-time scores into the 8x13 register file.
- On request, reads the stored count from address 0, then scans the score entries to find the best (minimum) score and the running sum.
- Then steps through each score on user button presses for 7-segment display.
- Owns one dedicated combinational read port of the register file; never writes.

Parameters:
- DATA_W, 13, width of a register-file word and of every score.
- ADDR_W, 3, register-file address width.
- MAX_SCORES, 4, clamp on the stored count; legal range 1..7.
- SUM_W, 16, width of the score accumulator.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high; forces the reset state immediately.
- buttonShow  in  1  level input, debounced upstream; rising edge starts a readout.
- buttonNext  in  1  level input, debounced upstream; rising edge advances the displayed score.
- registerData  in  DATA_W  read data; combinational from ReadAddress, valid in the same cycle.
- ReadAddress  out  ADDR_W  register-file read address, registered.
- displayScore  out  DATA_W  score currently shown.
- displayIndex  out  ADDR_W  address of the score shown; 0 when none.
- bestScore  out  DATA_W  minimum over the scanned scores.
- bestValid  out  1  high when at least one score was scanned.
- scoreSum  out  SUM_W  zero-extended sum of the scanned scores.
- busy  out  1  high in LOAD_COUNT and SCAN.
- done  out  1  high in DONE.

Behaviour:
- Both buttons go through internal rising-edge detectors, giving 1-cycle pulses; a held button acts once.
- Reset values: state IDLE; ReadAddress 0; displayScore 0; displayIndex 0; bestScore all-ones; bestValid 0; scoreSum 0; count 0; edge-detector history 0.
- Register-file layout contract: address 0 holds the count in bits [2:0]; valid scores sit at addresses 1..count.
- IDLE:
  - ReadAddress=0.
  - showPulse: clear bestScore to all-ones, bestValid to 0, scoreSum to 0, go to LOAD_COUNT.
- LOAD_COUNT (1 cycle):
  - Capture count = min(registerData[2:0], MAX_SCORES).
  - count==0: go to DONE with bestValid=0.
  - Otherwise: ReadAddress<=1, go to SCAN.
- SCAN (one cycle per entry, addr = ReadAddress):
  - scoreSum += registerData.
  - If registerData < bestScore, bestScore <= registerData.
  - bestValid <= 1.
  - If addr==count: ReadAddress<=1, go to SHOW_LOAD; else ReadAddress<=addr+1.
  - Latency from the showPulse edge to the first SHOW cycle is count+3 cycles.
- SHOW_LOAD (1 cycle): displayScore<=registerData, displayIndex<=ReadAddress, go to SHOW.
- SHOW:
  - Holds indefinitely.
  - nextPulse with displayIndex<count: ReadAddress<=displayIndex+1, go to SHOW_LOAD.
  - nextPulse with displayIndex==count: go to DONE.
- DONE:
  - displayScore<=bestScore; displayIndex<=0; ReadAddress<=0.
  - showPulse restarts exactly as from IDLE.
- Comparison is unsigned. Ties keep the earlier entry's value (value identical anyway).
- scoreSum never wraps at legal sizes: 7 x 8191 < 2^16.
- showPulse in LOAD_COUNT, SCAN, SHOW_LOAD or SHOW is ignored; no restart mid-scan.
- nextPulse outside SHOW is ignored.
- Simultaneous showPulse and nextPulse in SHOW: nextPulse wins.
- Simultaneous showPulse and nextPulse in DONE: restart.
- Reset mid-scan or mid-show: all outputs return to reset values asynchronously; the partial sum is discarded.
- Register-file contents changing during SHOW: the displayed value is the one captured at SHOW_LOAD and is not re-read.

Decomposition:
- Shared header: state encodings as localparams/defines.
  - IDLE=0, LOAD_COUNT=1, SCAN=2, SHOW_LOAD=3, SHOW=4, DONE=5.
  - Defaults for DATA_W, ADDR_W and MAX_SCORES, shared with the writing controller so the layout contract lives in one place.
- One sub-module, button_edge: a flip-flop with asynchronous clear plus an AND gate that produces a 1-cycle rising-edge pulse. Instantiated twice.

Test Plan:
- Memory {addr0=3, 1=250, 2=180, 3=410}, pulse buttonShow: busy for 4 cycles, reads addr 0,1,2,3; then bestScore=180, scoreSum=840, bestValid=1, displayScore=250, displayIndex=1.
- Same memory, three buttonNext presses: display 180/idx2, then 410/idx3, then DONE with displayScore=180, displayIndex=0, done=1.
- addr0=0, buttonShow: DONE 2 cycles after the edge; bestValid=0, scoreSum=0, displayScore=8191.
- addr0=7 with MAX_SCORES=4, entries 1..7 = 100..700: exactly addresses 1..4 scanned; scoreSum=1000, bestScore=100.
- Hold buttonNext high for 10 cycles in SHOW: advances exactly once. buttonShow pulsed during SCAN: no restart, results unchanged.
- Assert Reset at the second SCAN cycle: outputs immediately at reset values, state IDLE. A subsequent buttonShow rescans from scratch and produces correct results.

Source files
------------

// File: rtl/score_reader_pkg.sv
// Shared definitions for the score register file: word sizes, layout limits, FSM encoding.
// The writing controller imports the same package so the address-0 count contract lives in one place.
package score_reader_pkg;

    localparam int DATA_W         = 13;
    localparam int ADDR_W         = 3;
    localparam int SUM_W          = 16;
    localparam int DEF_MAX_SCORES = 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_COUNT = 3'd1,
        SCAN       = 3'd2,
        SHOW_LOAD  = 3'd3,
        SHOW       = 3'd4,
        DONE       = 3'd5
    } readerState_t;

    // Stored count lives in bits [2:0] of address 0; anything above the limit is clamped.
    function automatic logic [ADDR_W-1:0] clampCount(input logic [2:0] raw, input int maxScores);
        if (int'(raw) > maxScores) begin
            return ADDR_W'(maxScores);
        end
        return ADDR_W'(raw);
    endfunction

endpackage

// File: rtl/score_reader_if.sv
// Button inputs, register-file read port and result outputs of the score reader.
// master is the reader itself; slave is the surrounding system (buttons, register file, display).
interface score_reader_if;
    import score_reader_pkg::*;

    logic              buttonShow;
    logic              buttonNext;
    logic [DATA_W-1:0] registerData;
    logic [ADDR_W-1:0] ReadAddress;
    logic [DATA_W-1:0] displayScore;
    logic [ADDR_W-1:0] displayIndex;
    logic [DATA_W-1:0] bestScore;
    logic              bestValid;
    logic [SUM_W-1:0]  scoreSum;
    logic              busy;
    logic              done;

    modport master (
        input  buttonShow, buttonNext, registerData,
        output ReadAddress, displayScore, displayIndex, bestScore, bestValid, scoreSum, busy, done
    );

    modport slave (
        output buttonShow, buttonNext, registerData,
        input  ReadAddress, displayScore, displayIndex, bestScore, bestValid, scoreSum, busy, done
    );

endinterface

// File: rtl/score_reader_button_edge.sv
// Rising-edge detector for a debounced button: one-cycle pulse on the first cycle the level is high.
// A held button therefore produces exactly one pulse.
module score_reader_button_edge (
    input  logic Clock,
    input  logic Reset,
    input  logic level,
    output logic pulse
);

    logic levelPrev;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            levelPrev <= 1'b0;
        end else begin
            levelPrev <= level;
        end
    end

    assign pulse = level & ~levelPrev;

endmodule

// File: rtl/score_reader.sv
// Reads the stored score count, scans entries for minimum and sum, then pages through scores on button presses.
// Owns a combinational read port of the register file; all outputs are registered.
module score_reader
    import score_reader_pkg::*;
#(
    parameter int MAX_SCORES = DEF_MAX_SCORES
) (
    input  logic          Clock,
    input  logic          Reset,
    score_reader_if.master bus
);

    logic showPulse;
    logic nextPulse;

    score_reader_button_edge uShowEdge (
        .Clock (Clock),
        .Reset (Reset),
        .level (bus.buttonShow),
        .pulse (showPulse)
    );

    score_reader_button_edge uNextEdge (
        .Clock (Clock),
        .Reset (Reset),
        .level (bus.buttonNext),
        .pulse (nextPulse)
    );

    readerState_t      state;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] readAddr;
    logic [DATA_W-1:0] displayScore;
    logic [ADDR_W-1:0] displayIndex;
    logic [DATA_W-1:0] bestScore;
    logic              bestValid;
    logic [SUM_W-1:0]  scoreSum;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] loadCount;

    assign loadCount = clampCount(bus.registerData[2:0], MAX_SCORES);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            count        <= '0;
            readAddr     <= '0;
            displayScore <= '0;
            displayIndex <= '0;
            bestScore    <= '1;
            bestValid    <= 1'b0;
            scoreSum     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    readAddr <= '0;
                    if (showPulse) begin
                        bestScore <= '1;
                        bestValid <= 1'b0;
                        scoreSum  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= LOAD_COUNT;
                    end
                end

                LOAD_COUNT: begin
                    count <= loadCount;
                    if (loadCount == '0) begin
                        // Nothing stored: the display shows the untouched all-ones best.
                        displayScore <= bestScore;
                        displayIndex <= '0;
                        readAddr     <= '0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else begin
                        readAddr <= ADDR_W'(1);
                        state    <= SCAN;
                    end
                end

                SCAN: begin
                    scoreSum  <= scoreSum + SUM_W'(bus.registerData);
                    bestValid <= 1'b1;
                    if (bus.registerData < bestScore) begin
                        bestScore <= bus.registerData;
                    end
                    if (readAddr == count) begin
                        readAddr <= ADDR_W'(1);
                        busy     <= 1'b0;
                        state    <= SHOW_LOAD;
                    end else begin
                        readAddr <= readAddr + ADDR_W'(1);
                    end
                end

                SHOW_LOAD: begin
                    displayScore <= bus.registerData;
                    displayIndex <= readAddr;
                    state        <= SHOW;
                end

                SHOW: begin
                    // The shown value was captured in SHOW_LOAD and is not re-read here.
                    if (nextPulse) begin
                        if (displayIndex < count) begin
                            readAddr <= displayIndex + ADDR_W'(1);
                            state    <= SHOW_LOAD;
                        end else begin
                            displayScore <= bestScore;
                            displayIndex <= '0;
                            readAddr     <= '0;
                            done         <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end

                DONE: begin
                    displayScore <= bestScore;
                    displayIndex <= '0;
                    readAddr     <= '0;
                    if (showPulse) begin
                        bestScore <= '1;
                        bestValid <= 1'b0;
                        scoreSum  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= LOAD_COUNT;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ReadAddress  = readAddr;
    assign bus.displayScore = displayScore;
    assign bus.displayIndex = displayIndex;
    assign bus.bestScore    = bestScore;
    assign bus.bestValid    = bestValid;
    assign bus.scoreSum     = scoreSum;
    assign bus.busy         = busy;
    assign bus.done         = done;

endmodule

// File: tb/tb_score_reader.sv
// Directed bench for score_reader: register-file model driven from ReadAddress, hand-computed expectations.
module tb_score_reader;

    logic clk;
    logic rst;
    logic [12:0] mem [8];
    int total;
    int bad;

    score_reader_if sIf ();

    score_reader dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (sIf.master)
    );

    assign sIf.registerData = mem[sIf.ReadAddress];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic loadMem(input logic [12:0] c, input logic [12:0] a, input logic [12:0] b,
                           input logic [12:0] d);
        for (int i = 0; i < 8; i++) mem[i] = 13'd0;
        mem[0] = c;
        mem[1] = a;
        mem[2] = b;
        mem[3] = d;
    endtask

    task automatic pressNext();
        sIf.buttonNext = 1'b1;
        @(negedge clk);
        sIf.buttonNext = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        check({tag, ".addr"},  32'(sIf.ReadAddress),  0);
        check({tag, ".disp"},  32'(sIf.displayScore), 0);
        check({tag, ".idx"},   32'(sIf.displayIndex), 0);
        check({tag, ".best"},  32'(sIf.bestScore),    8191);
        check({tag, ".valid"}, 32'(sIf.bestValid),    0);
        check({tag, ".sum"},   32'(sIf.scoreSum),     0);
        check({tag, ".busy"},  32'(sIf.busy),         0);
        check({tag, ".done"},  32'(sIf.done),         0);
    endtask

    initial begin
        int busyCnt;
        int maxAddr;
        logic [2:0] addrSeq [8];

        total = 0;
        bad = 0;
        sIf.buttonShow = 1'b0;
        sIf.buttonNext = 1'b0;
        loadMem(13'd3, 13'd250, 13'd180, 13'd410);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic readout: three scores, busy spans LOAD_COUNT plus three SCAN cycles.
        busyCnt = 0;
        sIf.buttonShow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sIf.busy) begin
                addrSeq[busyCnt] = sIf.ReadAddress;
                busyCnt++;
            end
        end
        sIf.buttonShow = 1'b0;
        check("scan.busyCycles", busyCnt, 4);
        check("scan.addr0", 32'(addrSeq[0]), 0);
        check("scan.addr1", 32'(addrSeq[1]), 1);
        check("scan.addr2", 32'(addrSeq[2]), 2);
        check("scan.addr3", 32'(addrSeq[3]), 3);
        @(negedge clk);
        check("scan.best",  32'(sIf.bestScore),    180);
        check("scan.sum",   32'(sIf.scoreSum),     840);
        check("scan.valid", 32'(sIf.bestValid),    1);
        check("show1.disp", 32'(sIf.displayScore), 250);
        check("show1.idx",  32'(sIf.displayIndex), 1);
        check("show1.done", 32'(sIf.done),         0);

        pressNext();
        check("show2.disp", 32'(sIf.displayScore), 180);
        check("show2.idx",  32'(sIf.displayIndex), 2);
        pressNext();
        check("show3.disp", 32'(sIf.displayScore), 410);
        check("show3.idx",  32'(sIf.displayIndex), 3);
        pressNext();
        check("done.disp", 32'(sIf.displayScore), 180);
        check("done.idx",  32'(sIf.displayIndex), 0);
        check("done.flag", 32'(sIf.done),         1);
        check("done.addr", 32'(sIf.ReadAddress),  0);

        // Empty register file: LOAD_COUNT then straight to DONE.
        loadMem(13'd0, 13'd0, 13'd0, 13'd0);
        sIf.buttonShow = 1'b1;
        @(negedge clk);
        sIf.buttonShow = 1'b0;
        check("empty.busyLoad", 32'(sIf.busy), 1);
        check("empty.doneEarly", 32'(sIf.done), 0);
        @(negedge clk);
        check("empty.done",  32'(sIf.done),         1);
        check("empty.busy",  32'(sIf.busy),         0);
        check("empty.valid", 32'(sIf.bestValid),    0);
        check("empty.sum",   32'(sIf.scoreSum),     0);
        check("empty.disp",  32'(sIf.displayScore), 8191);

        // Count 7 clamps to 4; a second showPulse during SCAN must be ignored.
        for (int i = 0; i < 8; i++) mem[i] = 13'(i * 100);
        mem[0] = 13'd7;
        busyCnt = 0;
        maxAddr = 0;
        sIf.buttonShow = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sIf.busy) begin
                busyCnt++;
                if (int'(sIf.ReadAddress) > maxAddr) maxAddr = int'(sIf.ReadAddress);
            end
            if (i == 1) sIf.buttonShow = 1'b1;
            else        sIf.buttonShow = 1'b0;
        end
        check("clamp.busyCycles", busyCnt, 5);
        check("clamp.maxAddr",    maxAddr, 4);
        check("clamp.sum",   32'(sIf.scoreSum),     1000);
        check("clamp.best",  32'(sIf.bestScore),    100);
        check("clamp.disp",  32'(sIf.displayScore), 100);
        check("clamp.idx",   32'(sIf.displayIndex), 1);

        // A held next button advances exactly once.
        sIf.buttonNext = 1'b1;
        repeat (10) @(negedge clk);
        sIf.buttonNext = 1'b0;
        repeat (2) @(negedge clk);
        check("hold.idx",  32'(sIf.displayIndex), 2);
        check("hold.disp", 32'(sIf.displayScore), 200);
        pressNext();
        pressNext();
        check("clampLast.idx", 32'(sIf.displayIndex), 4);
        check("clampLast.disp", 32'(sIf.displayScore), 400);
        pressNext();
        check("clampDone.flag", 32'(sIf.done), 1);
        check("clampDone.disp", 32'(sIf.displayScore), 100);

        // Reset during the second SCAN cycle clears everything without a clock edge.
        loadMem(13'd3, 13'd250, 13'd180, 13'd410);
        sIf.buttonShow = 1'b1;
        @(negedge clk);
        sIf.buttonShow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midscan.addr", 32'(sIf.ReadAddress), 2);
        check("midscan.sum",  32'(sIf.scoreSum),    250);
        #1 rst = 1'b1;
        #1;
        checkReset("asyncReset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        sIf.buttonShow = 1'b1;
        repeat (6) @(negedge clk);
        sIf.buttonShow = 1'b0;
        @(negedge clk);
        check("rescan.best",  32'(sIf.bestScore),    180);
        check("rescan.sum",   32'(sIf.scoreSum),     840);
        check("rescan.valid", 32'(sIf.bestValid),    1);
        check("rescan.disp",  32'(sIf.displayScore), 250);
        check("rescan.idx",   32'(sIf.displayIndex), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
